// File: rtl/vga_timing_gen_if.sv
// Scan-timing bundle between the VGA timing generator and the background/sprite mappers.
// The generator drives it through the master view; mappers read it through the slave view.
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       hs_d;
    logic       vs_d;
    logic       blank_d;
    logic       line_start;
    logic       frame_start;

    modport master (
        output DrawX, DrawY, hs, vs, blank,
        output hs_d, vs_d, blank_d,
        output line_start, frame_start
    );

    modport slave (
        input DrawX, DrawY, hs, vs, blank,
        input hs_d, vs_d, blank_d,
        input line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA pixel-timing generator: scan counters, registered sync/blank decode,
// and a sync/blank copy delayed to line up with the mappers' RGB output.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       hs_r;
    logic       vs_r;
    logic       blank_r;
    logic       line_start_r;
    logic       frame_start_r;

    // NOTE: every variable gets a default before the if, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        h_next = h_cnt + 10'd1;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
    end

    // Decode is taken from the next counter values so the flags land in the same
    // cycle as the coordinates they describe, straight out of flops.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            blank_r       <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            h_cnt         <= h_next;
            v_cnt         <= v_next;
            hs_r          <= !((h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END));
            vs_r          <= !((v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END));
            blank_r       <= (h_next < H_VIS) && (v_next < V_VIS);
            line_start_r  <= (h_next == '0);
            frame_start_r <= (h_next == '0) && (v_next == '0);
        end
    end

    assign vga.DrawX       = h_cnt;
    assign vga.DrawY       = v_cnt;
    assign vga.hs          = hs_r;
    assign vga.vs          = vs_r;
    assign vga.blank       = blank_r;
    assign vga.line_start  = line_start_r;
    assign vga.frame_start = frame_start_r;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign vga.hs_d    = hs_r;
            assign vga.vs_d    = vs_r;
            assign vga.blank_d = blank_r;
        end else begin : g_delay
            // Each tap holds {hs, vs, blank}; tap[SYNC_DELAY-1] is the oldest.
            logic [2:0] taps [SYNC_DELAY];

            // NOTE: the taps are reset (unlike a RAM) so the delayed syncs come out
            // deasserted rather than unknown for the first SYNC_DELAY clocks.
            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        taps[i] <= 3'b110;
                    end
                end else begin
                    taps[0] <= {hs_r, vs_r, blank_r};
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        taps[i] <= taps[i-1];
                    end
                end
            end

            assign {vga.hs_d, vga.vs_d, vga.blank_d} = taps[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size instance for line timing and two
// shrunken-geometry instances (delay 2 and 0) so frame-level behaviour fits in a short run.
module tb_vga_timing_gen;

    // Shrunken geometry: 30 clocks per line, 20 lines per frame, 600 clocks per frame.
    localparam int S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 4;
    localparam int S_VV = 12, S_VF = 2, S_VS = 2, S_VB = 4;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;

    // {DrawX, DrawY, hs, vs, blank, hs_d, vs_d, blank_d, line_start, frame_start}
    localparam logic [27:0] RST_VEC  = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [27:0] FIRST_D2 = {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [27:0] FIRST_D0 = {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [2:0]  RST3     = 3'b110;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen_if if_full ();
    vga_timing_gen_if if_s2 ();
    vga_timing_gen_if if_s0 ();

    vga_timing_gen u_full (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vga     (if_full)
    );

    vga_timing_gen #(
        .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .SYNC_DELAY (2)
    ) u_s2 (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vga     (if_s2)
    );

    vga_timing_gen #(
        .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .SYNC_DELAY (0)
    ) u_s0 (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vga     (if_s0)
    );

    logic [27:0] obs_full, obs_s2, obs_s0;
    assign obs_full = {if_full.DrawX, if_full.DrawY, if_full.hs, if_full.vs, if_full.blank,
                       if_full.hs_d, if_full.vs_d, if_full.blank_d, if_full.line_start, if_full.frame_start};
    assign obs_s2   = {if_s2.DrawX, if_s2.DrawY, if_s2.hs, if_s2.vs, if_s2.blank,
                       if_s2.hs_d, if_s2.vs_d, if_s2.blank_d, if_s2.line_start, if_s2.frame_start};
    assign obs_s0   = {if_s0.DrawX, if_s0.DrawY, if_s0.hs, if_s0.vs, if_s0.blank,
                       if_s0.hs_d, if_s0.vs_d, if_s0.blank_d, if_s0.line_start, if_s0.frame_start};

    // Leaves every instance at the first sample after release, i.e. position (1,0).
    task automatic do_reset();
        @(negedge vga_clk);
        reset = 1'b1;
        repeat (3) @(negedge vga_clk);
        reset = 1'b0;
        @(negedge vga_clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge vga_clk);
        checks++;
        if (obs_full !== RST_VEC) begin
            errors++;
            $display("FAIL reset_full: got %h expected %h", obs_full, RST_VEC);
        end
        checks++;
        if (obs_s2 !== RST_VEC) begin
            errors++;
            $display("FAIL reset_s2: got %h expected %h", obs_s2, RST_VEC);
        end
        checks++;
        if (obs_s0 !== RST_VEC) begin
            errors++;
            $display("FAIL reset_s0: got %h expected %h", obs_s0, RST_VEC);
        end
        reset = 1'b0;
        @(negedge vga_clk);
        checks++;
        if (obs_full !== FIRST_D2) begin
            errors++;
            $display("FAIL first_edge_full: got %h expected %h", obs_full, FIRST_D2);
        end
        checks++;
        if (obs_s2 !== FIRST_D2) begin
            errors++;
            $display("FAIL first_edge_s2: got %h expected %h", obs_s2, FIRST_D2);
        end
        checks++;
        if (obs_s0 !== FIRST_D0) begin
            errors++;
            $display("FAIL first_edge_s0: got %h expected %h", obs_s0, FIRST_D0);
        end
    endtask

    // Full-size instance, continuing from (1,0) left by test_reset, for 800 clocks.
    task automatic test_line_timing();
        logic [9:0] ex = 10'd1;
        logic [9:0] ey = 10'd0;
        int bad = 0, hs_low = 0, ls_cnt = 0, vis_cnt = 0;
        logic exp_blank, exp_hs, exp_ls;
        for (int i = 0; i < 800; i++) begin
            @(negedge vga_clk);
            if (ex == 10'd799) begin
                ex = 10'd0;
                ey = ey + 10'd1;
            end else begin
                ex = ex + 10'd1;
            end
            exp_blank = (ex < 10'd640) && (ey < 10'd480);
            exp_hs    = !((ex >= 10'd656) && (ex < 10'd752));
            exp_ls    = (ex == 10'd0);
            if ({if_full.DrawX, if_full.DrawY} !== {ex, ey} || if_full.blank !== exp_blank ||
                if_full.hs !== exp_hs || if_full.line_start !== exp_ls || if_full.vs !== 1'b1) begin
                bad++;
            end
            if (if_full.hs === 1'b0) hs_low++;
            if (if_full.line_start === 1'b1) ls_cnt++;
            if (if_full.blank === 1'b1) vis_cnt++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL line_decode: %0d bad cycles, required 0", bad);
        end
        checks++;
        if (hs_low !== 96) begin
            errors++;
            $display("FAIL line_hs_width: got %0d clocks, required 96", hs_low);
        end
        checks++;
        if (ls_cnt !== 1) begin
            errors++;
            $display("FAIL line_start_count: got %0d, required 1", ls_cnt);
        end
        checks++;
        if (vis_cnt !== 640) begin
            errors++;
            $display("FAIL line_visible_count: got %0d, required 640", vis_cnt);
        end
        checks++;
        if (if_full.DrawY !== 10'd1) begin
            errors++;
            $display("FAIL line_advance: DrawY got %0d, required 1", if_full.DrawY);
        end
    endtask

    // Shrunken instance over two full frames.
    task automatic test_frame_timing();
        int sx = 1, sy = 0;
        int bad = 0, vs_low = 0, fs_cnt = 0, ls_cnt = 0, bottom_vis = 0;
        int fs_first = -1, fs_last = -1;
        logic exp_blank, exp_hs, exp_vs, exp_ls, exp_fs;
        do_reset();
        for (int i = 0; i < 2 * S_FRAME; i++) begin
            @(negedge vga_clk);
            sx++;
            if (sx == S_HT) begin
                sx = 0;
                sy++;
                if (sy == S_VT) sy = 0;
            end
            exp_blank = (sx < S_HV) && (sy < S_VV);
            exp_hs    = !((sx >= S_HV + S_HF) && (sx < S_HV + S_HF + S_HS));
            exp_vs    = !((sy >= S_VV + S_VF) && (sy < S_VV + S_VF + S_VS));
            exp_ls    = (sx == 0);
            exp_fs    = (sx == 0) && (sy == 0);
            if (int'(if_s2.DrawX) != sx || int'(if_s2.DrawY) != sy || if_s2.blank !== exp_blank ||
                if_s2.hs !== exp_hs || if_s2.vs !== exp_vs || if_s2.line_start !== exp_ls ||
                if_s2.frame_start !== exp_fs) begin
                bad++;
            end
            if (if_s2.vs === 1'b0) vs_low++;
            if (if_s2.line_start === 1'b1) ls_cnt++;
            if (if_s2.blank === 1'b1 && sy >= S_VV) bottom_vis++;
            if (if_s2.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
                fs_last = i;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL frame_decode: %0d bad cycles, required 0", bad);
        end
        checks++;
        if (vs_low !== 2 * S_VS * S_HT) begin
            errors++;
            $display("FAIL frame_vs_width: got %0d clocks, required %0d", vs_low, 2 * S_VS * S_HT);
        end
        checks++;
        if (fs_cnt !== 2) begin
            errors++;
            $display("FAIL frame_start_count: got %0d, required 2", fs_cnt);
        end
        checks++;
        if (fs_last - fs_first !== S_FRAME) begin
            errors++;
            $display("FAIL frame_period: got %0d clocks, required %0d", fs_last - fs_first, S_FRAME);
        end
        checks++;
        if (ls_cnt !== 2 * S_VT) begin
            errors++;
            $display("FAIL frame_line_count: got %0d, required %0d", ls_cnt, 2 * S_VT);
        end
        checks++;
        if (bottom_vis !== 0) begin
            errors++;
            $display("FAIL frame_bottom_blank: got %0d visible clocks, required 0", bottom_vis);
        end
    endtask

    task automatic test_wrap_corner();
        logic [27:0] exp_last, exp_wrap2, exp_wrap0;
        // (29,19): outside both syncs and blanked; delayed copy is (27,19), also 1,1,0.
        exp_last  = {10'd29, 10'd19, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_wrap2 = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_wrap0 = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        repeat (S_FRAME - 2) @(negedge vga_clk);
        checks++;
        if (obs_s2 !== exp_last) begin
            errors++;
            $display("FAIL wrap_last_pixel: got %h expected %h", obs_s2, exp_last);
        end
        @(negedge vga_clk);
        checks++;
        if (obs_s2 !== exp_wrap2) begin
            errors++;
            $display("FAIL wrap_origin_s2: got %h expected %h", obs_s2, exp_wrap2);
        end
        checks++;
        if (obs_s0 !== exp_wrap0) begin
            errors++;
            $display("FAIL wrap_origin_s0: got %h expected %h", obs_s0, exp_wrap0);
        end
    endtask

    task automatic test_delay_alignment();
        logic [2:0] hist_s2 [$];
        logic [2:0] hist_full [$];
        logic [2:0] exp2, expf;
        int bad2 = 0, badf = 0, bad0 = 0, hs_d_low = 0;
        do_reset();
        hist_s2   = '{RST3, RST3};
        hist_full = '{RST3, RST3};
        for (int i = 0; i < S_FRAME; i++) begin
            if (i > 0) @(negedge vga_clk);
            exp2 = hist_s2.pop_front();
            expf = hist_full.pop_front();
            if ({if_s2.hs_d, if_s2.vs_d, if_s2.blank_d} !== exp2) bad2++;
            if ({if_full.hs_d, if_full.vs_d, if_full.blank_d} !== expf) badf++;
            if ({if_s0.hs_d, if_s0.vs_d, if_s0.blank_d} !== {if_s0.hs, if_s0.vs, if_s0.blank}) bad0++;
            if (if_s2.hs_d === 1'b0) hs_d_low++;
            hist_s2.push_back({if_s2.hs, if_s2.vs, if_s2.blank});
            hist_full.push_back({if_full.hs, if_full.vs, if_full.blank});
        end
        checks++;
        if (bad2 !== 0) begin
            errors++;
            $display("FAIL delay2_s2: %0d bad cycles, required 0", bad2);
        end
        checks++;
        if (badf !== 0) begin
            errors++;
            $display("FAIL delay2_full: %0d bad cycles, required 0", badf);
        end
        checks++;
        if (bad0 !== 0) begin
            errors++;
            $display("FAIL delay0_s0: %0d bad cycles, required 0", bad0);
        end
        checks++;
        if (hs_d_low !== S_HS * S_VT) begin
            errors++;
            $display("FAIL delay2_hs_activity: got %0d low clocks, required %0d", hs_d_low, S_HS * S_VT);
        end
    endtask

    task automatic test_mid_frame_reset();
        do_reset();
        repeat (8 * S_HT + 10 - 1) @(negedge vga_clk);
        checks++;
        if ({if_s2.DrawX, if_s2.DrawY} !== {10'd10, 10'd8}) begin
            errors++;
            $display("FAIL mid_position: got (%0d,%0d) expected (10,8)", if_s2.DrawX, if_s2.DrawY);
        end
        #5;
        reset = 1'b1;
        #1;
        checks++;
        if (obs_full !== RST_VEC) begin
            errors++;
            $display("FAIL mid_reset_full: got %h expected %h", obs_full, RST_VEC);
        end
        checks++;
        if (obs_s2 !== RST_VEC) begin
            errors++;
            $display("FAIL mid_reset_s2: got %h expected %h", obs_s2, RST_VEC);
        end
        checks++;
        if (obs_s0 !== RST_VEC) begin
            errors++;
            $display("FAIL mid_reset_s0: got %h expected %h", obs_s0, RST_VEC);
        end
        repeat (4) @(negedge vga_clk);
        reset = 1'b0;
        @(negedge vga_clk);
        checks++;
        if (obs_full !== FIRST_D2) begin
            errors++;
            $display("FAIL mid_release_full: got %h expected %h", obs_full, FIRST_D2);
        end
        checks++;
        if (obs_s2 !== FIRST_D2) begin
            errors++;
            $display("FAIL mid_release_s2: got %h expected %h", obs_s2, FIRST_D2);
        end
        checks++;
        if (obs_s0 !== FIRST_D0) begin
            errors++;
            $display("FAIL mid_release_s0: got %h expected %h", obs_s0, FIRST_D0);
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_wrap_corner();
        test_delay_alignment();
        test_mid_frame_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
